rca_pipelined_param: RTL and testbench

- Parametrised pipelined ripple-carry adder/subtractor: WIDTH-bit operands split into CHUNK-bit slices, one slice per pipeline stage, carry registered between stages.
- Adds what a fixed 4-bit, 1-bit-per-stage adder lacks: configurable width and slice size, add/subtract mode, valid tagging, global stall, signed-overflow flag, and reset.
- Sits in the datapath library as the throughput-oriented adder: one operation accepted per cycle, fixed latency.

---
 rtl/rca_pipelined_param_if.sv | 29 ++
 rtl/rca_pipelined_param.sv | 100 ++++++++++
 tb/tb_rca_pipelined_param.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rca_pipelined_param_if.sv
// Operand/result bundle for rca_pipelined_param. The master drives operands and
// enable; the slave (the adder) returns the tagged result.
interface rca_pipelined_param_if #(
    parameter int WIDTH = 16
);
    // Handshake: a result is new only in a cycle where out_valid=1 and the
    // previous edge was enabled; there is no back-pressure, enable=0 freezes
    // the whole pipeline and in_valid=0 injects a bubble.
    logic             enable;
    logic             in_valid;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output enable, in_valid, sub, cin, a, b,
        input  out_valid, sum, cout, overflow
    );

    modport slave (
        input  enable, in_valid, sub, cin, a, b,
        output out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/rca_pipelined_param.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage,
// carry registered between stages, latency WIDTH/CHUNK enabled edges.
module rca_pipelined_param #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    rca_pipelined_param_if.slave  bus
);
    localparam int STAGES = WIDTH / ((CHUNK >= 1) ? CHUNK : 1);
    localparam int PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

    if ((CHUNK < 1) || (WIDTH % ((CHUNK >= 1) ? CHUNK : 1) != 0)) begin : g_bad_param
        $error("rca_pipelined_param: WIDTH must be a positive multiple of CHUNK");
    end

    // Inter-stage registers: entry k holds the state after stage k has run.
    logic [WIDTH-1:0] a_q [PIPE];
    logic [WIDTH-1:0] b_q [PIPE];
    logic [WIDTH-1:0] s_q [PIPE];
    logic             c_q [PIPE];
    logic             v_q [PIPE];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    // Stage inputs and combinational stage results.
    logic [WIDTH-1:0] a_st [STAGES];
    logic [WIDTH-1:0] b_st [STAGES];
    logic [WIDTH-1:0] s_st [STAGES];
    logic             c_st [STAGES];
    logic             v_st [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];
    logic             c_nx [STAGES];
    logic             ovf_nx;

    always_comb begin
        a_st[0] = bus.a;
        b_st[0] = bus.sub ? ~bus.b : bus.b;
        c_st[0] = bus.sub ? ~bus.cin : bus.cin;
        s_st[0] = '0;
        v_st[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_st[k] = a_q[k-1];
            b_st[k] = b_q[k-1];
            s_st[k] = s_q[k-1];
            c_st[k] = c_q[k-1];
            v_st[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k] = s_st[k];
            {c_nx[k], s_nx[k][k*CHUNK +: CHUNK]} =
                {1'b0, a_st[k][k*CHUNK +: CHUNK]} +
                {1'b0, b_st[k][k*CHUNK +: CHUNK]} +
                {{CHUNK{1'b0}}, c_st[k]};
        end
        // Carry into the MSB is recovered from the MSB's own sum bit.
        ovf_nx = a_st[STAGES-1][WIDTH-1] ^ b_st[STAGES-1][WIDTH-1] ^
                 s_nx[STAGES-1][WIDTH-1] ^ c_nx[STAGES-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.enable) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_q[k] <= a_st[k];
                b_q[k] <= b_st[k];
                s_q[k] <= s_nx[k];
                c_q[k] <= c_nx[k];
                v_q[k] <= v_st[k];
            end
            valid_q <= v_st[STAGES-1];
            // Bubbles leave the last valid result on the outputs.
            if (v_st[STAGES-1]) begin
                sum_q  <= s_nx[STAGES-1];
                cout_q <= c_nx[STAGES-1];
                ovf_q  <= ovf_nx;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_rca_pipelined_param.sv
// Bench for rca_pipelined_param: directed 16/4 vectors checked inline, plus
// 8/1 and 8/8 instances checked through expected queues with latency tags.
module tb_rca_pipelined_param;
  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  rca_pipelined_param_if #(.WIDTH(16)) bus16 ();
  rca_pipelined_param_if #(.WIDTH(8))  bus8a ();
  rca_pipelined_param_if #(.WIDTH(8))  bus8b ();

  rca_pipelined_param #(.WIDTH(16), .CHUNK(4)) dut16 (.clock(clock), .reset(reset), .bus(bus16));
  rca_pipelined_param #(.WIDTH(8),  .CHUNK(1)) dut8a (.clock(clock), .reset(reset), .bus(bus8a));
  rca_pipelined_param #(.WIDTH(8),  .CHUNK(8)) dut8b (.clock(clock), .reset(reset), .bus(bus8b));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // driver tasks, 16-bit
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
  endtask

  task automatic wait_out16(input string tag, input int exp_lat);
    int cnt;
    cnt = 0;
    while (!bus16.out_valid && cnt < 20) begin
      step();
      cnt++;
    end
    check({tag, "_lat"}, cnt, exp_lat);
  endtask

  task automatic res16(input string tag, input logic [15:0] s, input logic c, input logic v);
    check({tag, "_ov"},   bus16.out_valid, 1'b1);
    check({tag, "_sum"},  bus16.sum, s);
    check({tag, "_cout"}, bus16.cout, c);
    check({tag, "_ovf"},  bus16.overflow, v);
  endtask

  // scoreboard, 8-bit instances: {overflow, cout, sum}
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q8[$];
  int         idx_q1[$];
  int         idx_q8[$];
  int         ecnt8 = 0;

  logic [7:0] va [8];
  logic [7:0] vb [8];
  logic       vc [8];
  logic       vs [8];
  logic [9:0] vexp [8];

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic iv, input logic en);
    bus8a.a = a; bus8a.b = b; bus8a.cin = cin; bus8a.sub = sub; bus8a.in_valid = iv; bus8a.enable = en;
    bus8b.a = a; bus8b.b = b; bus8b.cin = cin; bus8b.sub = sub; bus8b.in_valid = iv; bus8b.enable = en;
  endtask

  task automatic issue8(input int i);
    drive8(va[i], vb[i], vc[i], vs[i], 1'b1, 1'b1);
    exp_q1.push_back(vexp[i]); idx_q1.push_back(ecnt8 + 1);
    exp_q8.push_back(vexp[i]); idx_q8.push_back(ecnt8 + 1);
    step();
  endtask

  always @(posedge clock) begin
    logic       en_s;
    logic [9:0] e;
    int         idx;
    en_s = bus8a.enable & ~reset;
    if (en_s) ecnt8++;
    #1;
    if (en_s && bus8a.out_valid) begin
      if (exp_q1.size() == 0) check("c1_extra", 1, 0);
      else begin
        e = exp_q1.pop_front(); idx = idx_q1.pop_front();
        check("c1_res", {bus8a.overflow, bus8a.cout, bus8a.sum}, e);
        check("c1_lat", ecnt8 - idx, 7);
      end
    end
    if (en_s && bus8b.out_valid) begin
      if (exp_q8.size() == 0) check("c8_extra", 1, 0);
      else begin
        e = exp_q8.pop_front(); idx = idx_q8.pop_front();
        check("c8_res", {bus8b.overflow, bus8b.cout, bus8b.sum}, e);
        check("c8_lat", ecnt8 - idx, 0);
      end
    end
  end

  initial begin
    int pulses;
    va[0] = 8'h7F; vb[0] = 8'h01; vc[0] = 0; vs[0] = 0; vexp[0] = {1'b1, 1'b0, 8'h80};
    va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1; vs[1] = 0; vexp[1] = {1'b0, 1'b1, 8'hFF};
    va[2] = 8'h80; vb[2] = 8'h01; vc[2] = 0; vs[2] = 1; vexp[2] = {1'b1, 1'b1, 8'h7F};
    va[3] = 8'h00; vb[3] = 8'h01; vc[3] = 0; vs[3] = 1; vexp[3] = {1'b0, 1'b0, 8'hFF};
    va[4] = 8'h3C; vb[4] = 8'h0F; vc[4] = 1; vs[4] = 0; vexp[4] = {1'b0, 1'b0, 8'h4C};
    va[5] = 8'h40; vb[5] = 8'h40; vc[5] = 0; vs[5] = 0; vexp[5] = {1'b1, 1'b0, 8'h80};
    va[6] = 8'h05; vb[6] = 8'h03; vc[6] = 1; vs[6] = 1; vexp[6] = {1'b0, 1'b1, 8'h01};
    va[7] = 8'h80; vb[7] = 8'h80; vc[7] = 0; vs[7] = 0; vexp[7] = {1'b1, 1'b1, 8'h00};

    reset = 1'b1;
    bus16.enable = 1'b1; bus16.in_valid = 1'b0; bus16.sub = 1'b0; bus16.cin = 1'b0;
    bus16.a = '0; bus16.b = '0;
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_ov",   bus16.out_valid, 0);
    check("rst_sum",  bus16.sum, 0);
    check("rst_cout", bus16.cout, 0);
    check("rst_ovf",  bus16.overflow, 0);
    step(); step();
    reset = 1'b0;
    step();

    // single add, then hold on bubbles
    issue16(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    wait_out16("A", 3);
    res16("A", 16'h2233, 1'b0, 1'b0);
    step();
    check("A_pulse", bus16.out_valid, 0);
    check("A_hold",  bus16.sum, 16'h2233);

    // back-to-back
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_out16("B1", 2);
    res16("B1", 16'h0000, 1'b1, 1'b0);
    step();
    res16("B2", 16'h8000, 1'b0, 1'b1);
    step();
    check("B_end", bus16.out_valid, 0);

    // subtract
    issue16(16'h0005, 16'h0007, 1'b0, 1'b1);
    issue16(16'h8000, 16'h0001, 1'b0, 1'b1);
    issue16(16'h0010, 16'h0001, 1'b1, 1'b1);
    wait_out16("S1", 1);
    res16("S1", 16'hFFFE, 1'b0, 1'b0);
    step();
    res16("S2", 16'h7FFF, 1'b1, 1'b1);
    step();
    res16("S3", 16'h000E, 1'b1, 1'b0);
    step();

    // stall with two in flight; garbage presented while stalled is ignored
    issue16(16'h1111, 16'h2222, 1'b0, 1'b0);
    issue16(16'hA000, 16'h6000, 1'b0, 1'b0);
    bus16.enable = 1'b0;
    repeat (3) begin
      bus16.a = 16'($urandom_range(0, 65535)); bus16.in_valid = 1'b1;
      step();
      check("stall_ov", bus16.out_valid, 0);
    end
    bus16.in_valid = 1'b0; bus16.enable = 1'b1;
    wait_out16("T1", 2);
    res16("T1", 16'h3333, 1'b0, 1'b0);
    bus16.enable = 1'b0;
    repeat (2) begin
      step();
      check("held_ov",  bus16.out_valid, 1);
      check("held_sum", bus16.sum, 16'h3333);
    end
    bus16.enable = 1'b1;
    step();
    res16("T2", 16'h0000, 1'b1, 1'b0);
    step();

    // reset with work in flight
    issue16(16'h0101, 16'h0202, 1'b0, 1'b0);
    issue16(16'h7000, 16'h7000, 1'b0, 1'b0);
    issue16(16'h0F0F, 16'h0001, 1'b0, 1'b0);
    step();
    res16("R0", 16'h0303, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("R_ov",   bus16.out_valid, 0);
    check("R_sum",  bus16.sum, 0);
    check("R_cout", bus16.cout, 0);
    check("R_ovf",  bus16.overflow, 0);
    #1;
    reset = 1'b0;
    pulses = 0;
    repeat (8) begin
      step();
      if (bus16.out_valid) pulses++;
    end
    check("R_pulses", pulses, 0);

    // 8-bit instances: bubbles and a stall mixed into the stream
    for (int i = 0; i < 8; i++) begin
      issue8(i);
      if (i == 2) begin
        drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
      end
      if (i == 4) begin
        repeat (2) begin
          drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b1, 1'b0);
          step();
        end
      end
    end
    drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (12) step();
    check("c1_drain", exp_q1.size(), 0);
    check("c8_drain", exp_q8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
